panda_mem_ctrl: RTL and testbench
=================================

PANDA_MEM_CTRL -- requirements
Module: panda_mem_ctrl

Interface
REQ-001 SHALL have parameter DataWidth, default 32: word width in bits, a multiple of 8.
REQ-002 SHALL have parameter Depth, default 1024: words in the attached single-port RAM.
REQ-003 SHALL have parameter RamOutputReg, default 1'b1: 1 = RAM read data valid one cycle after issue; 0 = valid in the issue cycle.
REQ-004 SHALL have parameter RspDepth, default 3: response buffer entries, minimum 2.
REQ-005 SHALL have one clock, clk_i, input, 1 bit; all state is updated on its rising edge.
REQ-006 SHALL have rst_ni, input, 1 bit: reset is synchronous and active-low.
REQ-007 SHALL have req_valid_i, input, 1: a request is offered.
REQ-008 SHALL have req_ready_o, output, 1: the request is accepted when valid and ready are both high.
REQ-009 SHALL have req_we_i, input, 1: 1 = store, 0 = load.
REQ-010 SHALL have req_be_i, input, DataWidth/8: byte enables for a store.
REQ-011 SHALL have req_addr_i, input, 32: byte address.
REQ-012 SHALL have req_wdata_i, input, DataWidth: store data.
REQ-013 SHALL have rsp_valid_o / rsp_ready_i, output / input, 1 each: response handshake.
REQ-014 SHALL have rsp_rdata_o, output, DataWidth: load data; 0 for stores and errors.
REQ-015 SHALL have rsp_err_o, output, 1: the address was out of range.
REQ-016 SHALL have ram_ce_o, ram_we_o, ram_addr_o, ram_wdata_o, outputs, widths 1, DataWidth/8, $clog2(Depth), DataWidth: RAM port.
REQ-017 SHALL have ram_rdata_i, input, DataWidth: RAM read data.

Function
REQ-018 SHALL form the word index as req_addr_i[2+:$clog2(Depth)] for DataWidth=32, i.e. byte-offset bits are dropped; the byte lanes are selected by req_be_i.
REQ-019 SHALL flag a request out-of-range when any req_addr_i bit above the word index is nonzero.
REQ-020 SHALL drive the RAM port combinationally in the acceptance cycle for an in-range request: ram_ce_o=1, ram_we_o=req_be_i if req_we_i else 0, ram_addr_o=index, ram_wdata_o=req_wdata_i.
REQ-021 SHALL hold ram_ce_o=0 and ram_we_o=0 in every other cycle, including out-of-range acceptances.
REQ-022 SHALL produce exactly one response per accepted request, in acceptance order.
REQ-023 SHALL capture ram_rdata_i into the response buffer at the end of the issue cycle when RamOutputReg=0, or at the end of issue+1 when RamOutputReg=1.
REQ-024 SHALL give a load its first possible rsp_valid_o in cycle issue+1 when RamOutputReg=0, or issue+2 when RamOutputReg=1.
REQ-025 SHALL push the response for stores and errors at the same pipeline point as loads, so that ordering is preserved.
REQ-026 SHALL track credits: req_ready_o=1 iff (responses in flight + buffer occupancy) < RspDepth.
REQ-027 SHALL derive req_ready_o from registered state only, with no combinational path from rsp_ready_i.
REQ-028 SHALL treat a credit freed by a pop and a new acceptance in the same cycle as a net count change of zero.
REQ-029 SHALL hold rsp_valid_o and the response fields stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-030 SHALL sustain one request per cycle with continuous rsp_ready_i=1 when RspDepth >= 2+RamOutputReg.
REQ-031 SHALL accept no request when the buffer is full, and SHALL NOT lose any captured data.

Reset
REQ-032 SHALL, while rst_ni=0 at a rising edge, clear in-flight tracking and buffer occupancy, and drop in-flight requests without a response.
REQ-033 SHALL show these values in the first cycle after reset: rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, req_ready_o=1.
REQ-034 SHALL hold ram_ce_o=0 and ram_we_o=0 during reset, regardless of req_valid_i.

Structure
REQ-035 SHALL have a shared package panda_pkg that holds the mem_rsp_t struct {rdata, err} and the constant MemAddrWidth=32.
REQ-036 SHALL implement the response buffer as a sub-module panda_fifo, parameterised by width and depth, with push/pop, full/empty and a count output.
REQ-037 SHALL keep the in-flight pipeline (valid, we, err per stage) inside panda_mem_ctrl.

Verification
REQ-038 SHALL cover this scenario (RamOutputReg=1): store addr 0x10, be=4'b0011, wdata 0xAABBCCDD over a word holding 0x11223344, then load addr 0x10 -> rdata 0x1122CCDD, err=0, responses in order.
REQ-039 SHALL cover this scenario: load addr 0x1000 with Depth=1024 -> ram_ce_o stays 0, response err=1, rdata=0.
REQ-040 SHALL cover this scenario: rsp_ready_i=0 while issuing 5 back-to-back loads -> exactly 3 accepted, req_ready_o=0; after release, 3 responses in order, then the remaining 2 are accepted.
REQ-041 SHALL cover this scenario: 100 back-to-back loads with rsp_ready_i=1 -> 100 consecutive valid responses after the initial latency of 2 cycles.
REQ-042 SHALL cover this scenario: rst_ni=0 with 2 loads in flight -> no response is emitted; the next cycle after reset shows rsp_valid_o=0 and req_ready_o=1.
REQ-043 SHALL cover this scenario (RamOutputReg=0): single load -> rsp_valid_o in cycle issue+1 with the correct data.

Source files
------------

// File: rtl/panda_pkg.sv
// Shared types and constants for the panda memory path.
// The response struct is sized for the MemDataWidth datapath.
package panda_pkg;

    localparam int MemAddrWidth = 32;
    localparam int MemDataWidth = 32;

    typedef struct packed {
        logic [MemDataWidth-1:0] rdata;
        logic                    err;
    } mem_rsp_t;

endpackage

// File: rtl/panda_fifo.sv
// Small in-order response buffer with push/pop, full/empty and occupancy count.
// A push into a full buffer is accepted only if a pop frees the head slot in the same cycle.
module panda_fifo #(
    parameter int Width = 8,
    parameter int Depth = 2,
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);
    localparam int PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && (!full_o || pop_i);
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; an entry is only observable after it was pushed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/panda_mem_ctrl.sv
// Single-port RAM controller: valid/ready requests in, in-order responses out.
// Credits cover the RAM read stage plus the response buffer, so read data is never dropped.
module panda_mem_ctrl
    import panda_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int Depth        = 1024,
    parameter bit RamOutputReg = 1'b1,
    parameter int RspDepth     = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [DataWidth/8-1:0]   req_be_i,
    input  logic [MemAddrWidth-1:0]  req_addr_i,
    input  logic [DataWidth-1:0]     req_wdata_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [DataWidth-1:0]     rsp_rdata_o,
    output logic                     rsp_err_o,
    output logic                     ram_ce_o,
    output logic [DataWidth/8-1:0]   ram_we_o,
    output logic [$clog2(Depth)-1:0] ram_addr_o,
    output logic [DataWidth-1:0]     ram_wdata_o,
    input  logic [DataWidth-1:0]     ram_rdata_i
);
    localparam int BeW  = DataWidth / 8;
    localparam int OffW = $clog2(BeW);
    localparam int IdxW = $clog2(Depth);
    localparam int CntW = $clog2(RspDepth + 1);

    logic            accept, out_of_range;
    logic            s1_valid_q, s1_valid_d;
    logic            s1_we_q, s1_we_d;
    logic            s1_err_q, s1_err_d;
    logic            push, push_we, push_err, pop;
    logic [CntW:0]   occupancy;
    mem_rsp_t        push_rsp, head_rsp;
    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;

    assign out_of_range = |req_addr_i[MemAddrWidth-1:OffW+IdxW];

    // NOTE: every signal written here is assigned on all paths, so no latch is inferred.
    always_comb begin
        // Ready sees only registered occupancy, never rsp_ready_i.
        occupancy   = {1'b0, fifo_count} + (CntW+1)'(RamOutputReg && s1_valid_q);
        req_ready_o = !fifo_full && (occupancy < (CntW+1)'(RspDepth));
        accept      = rst_ni && req_valid_i && req_ready_o;

        ram_ce_o    = accept && !out_of_range;
        ram_we_o    = (ram_ce_o && req_we_i) ? req_be_i : '0;
        ram_addr_o  = req_addr_i[OffW +: IdxW];
        ram_wdata_o = req_wdata_i;

        s1_valid_d  = accept;
        s1_we_d     = req_we_i;
        s1_err_d    = out_of_range;

        // Stores and errors ride the same stage as loads to keep responses ordered.
        if (RamOutputReg) begin
            push     = s1_valid_q;
            push_we  = s1_we_q;
            push_err = s1_err_q;
        end else begin
            push     = accept;
            push_we  = req_we_i;
            push_err = out_of_range;
        end
        push_rsp.err   = push_err;
        push_rsp.rdata = (push_we || push_err) ? '0 : ram_rdata_i;
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_we_q    <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_we_q    <= s1_we_d;
            s1_err_q   <= s1_err_d;
        end
    end

    panda_fifo #(
        .Width ($bits(mem_rsp_t)),
        .Depth (RspDepth)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (push_rsp),
        .pop_i   (pop),
        .data_o  (head_rsp),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign rsp_valid_o = !fifo_empty;
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign rsp_rdata_o = fifo_empty ? '0 : head_rsp.rdata;
    assign rsp_err_o   = !fifo_empty && head_rsp.err;

endmodule

// File: tb/tb_panda_mem_ctrl.sv
// Randomized scoreboard bench for panda_mem_ctrl, with a behavioural memory model
// and directed scenarios for back-pressure, throughput, reset and the zero-latency RAM.
module tb_panda_mem_ctrl;
    import panda_pkg::*;

    localparam int DEPTH = 1024;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    logic        req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
    logic [3:0]  req_be_i = '0;
    logic [31:0] req_addr_i = '0, req_wdata_i = '0;
    logic        rsp_valid_o, rsp_ready_i = 1'b1, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        ram_ce_o;
    logic [3:0]  ram_we_o;
    logic [9:0]  ram_addr_o;
    logic [31:0] ram_wdata_o, ram_rdata_i;

    logic        z_req_valid_i = 1'b0, z_req_ready_o, z_req_we_i = 1'b0;
    logic [3:0]  z_req_be_i = '0;
    logic [31:0] z_req_addr_i = '0, z_req_wdata_i = '0;
    logic        z_rsp_valid_o, z_rsp_ready_i = 1'b1, z_rsp_err_o;
    logic [31:0] z_rsp_rdata_o;
    logic        z_ram_ce_o;
    logic [3:0]  z_ram_we_o;
    logic [9:0]  z_ram_addr_o;
    logic [31:0] z_ram_wdata_o, z_ram_rdata_i;

    panda_mem_ctrl #(.DataWidth(32), .Depth(DEPTH), .RamOutputReg(1'b1), .RspDepth(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_be_i(req_be_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    panda_mem_ctrl #(.DataWidth(32), .Depth(DEPTH), .RamOutputReg(1'b0), .RspDepth(3)) dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(z_req_valid_i), .req_ready_o(z_req_ready_o), .req_we_i(z_req_we_i),
        .req_be_i(z_req_be_i), .req_addr_i(z_req_addr_i), .req_wdata_i(z_req_wdata_i),
        .rsp_valid_o(z_rsp_valid_o), .rsp_ready_i(z_rsp_ready_i),
        .rsp_rdata_o(z_rsp_rdata_o), .rsp_err_o(z_rsp_err_o),
        .ram_ce_o(z_ram_ce_o), .ram_we_o(z_ram_we_o), .ram_addr_o(z_ram_addr_o),
        .ram_wdata_o(z_ram_wdata_o), .ram_rdata_i(z_ram_rdata_i)
    );

    // Registered-output RAM; read data is scrambled on idle cycles to expose mistimed captures.
    logic [31:0] ram [DEPTH];
    always @(posedge clk_i) begin
        if (ram_ce_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_we_o[b]) ram[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
            ram_rdata_i <= ram[ram_addr_o];
        end else begin
            ram_rdata_i <= $urandom();
        end
    end

    logic [31:0] zram [DEPTH];
    assign z_ram_rdata_i = z_ram_ce_o ? zram[z_ram_addr_o] : 32'hDEAD_BEEF;
    always @(posedge clk_i) begin
        if (z_ram_ce_o)
            for (int b = 0; b < 4; b++)
                if (z_ram_we_o[b]) zram[z_ram_addr_o][b*8 +: 8] <= z_ram_wdata_o[b*8 +: 8];
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    mem_rsp_t    exp_q[$];
    logic [31:0] model [DEPTH];
    int          rdy_mode = 1;
    bit          track = 1'b0;
    int          pop_cyc_q[$];
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        mem_rsp_t e;
        forever begin
            @(negedge clk_i); #1;
            if (rst_ni && rsp_valid_o && rsp_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_err", rsp_err_o, e.err);
                    check("rsp_rdata", rsp_rdata_o, e.rdata);
                end
                last_rdata = rsp_rdata_o;
                last_err   = rsp_err_o;
                if (track) pop_cyc_q.push_back(cyc);
            end
        end
    end

    function automatic bit is_oor(input logic [31:0] addr);
        return addr[31:12] != '0;
    endfunction

    // Reference: a word-addressed memory, updated in acceptance order.
    task automatic model_accept(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wdata);
        mem_rsp_t r;
        int idx = int'(addr[11:2]);
        r.err = is_oor(addr);
        r.rdata = '0;
        if (!r.err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model[idx][b*8 +: 8] = wdata[b*8 +: 8];
            end else begin
                r.rdata = model[idx];
            end
        end
        exp_q.push_back(r);
    endtask

    task automatic set_rsp_ready();
        case (rdy_mode)
            0:       rsp_ready_i = 1'b0;
            1:       rsp_ready_i = 1'b1;
            default: rsp_ready_i = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic offer_cycle(input logic we, input logic [3:0] be, input logic [31:0] addr,
                               input logic [31:0] wdata, output bit acc);
        bit exp_ce;
        @(negedge clk_i);
        set_rsp_ready();
        req_valid_i = 1'b1; req_we_i = we; req_be_i = be;
        req_addr_i = addr; req_wdata_i = wdata;
        acc = req_ready_o;
        if (acc) model_accept(we, be, addr, wdata);
        #1;
        exp_ce = acc && !is_oor(addr);
        check("ram_ce", ram_ce_o, exp_ce);
        check("ram_we", ram_we_o, (exp_ce && we) ? be : 4'h0);
        if (exp_ce) begin
            check("ram_addr", ram_addr_o, addr[11:2]);
            if (we) check("ram_wdata", ram_wdata_o, wdata);
        end
    endtask

    task automatic send(input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata);
        bit acc = 1'b0;
        int waited = 0;
        while (!acc && waited < 100) begin
            offer_cycle(we, be, addr, wdata, acc);
            waited++;
        end
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic idle_cycle();
        @(negedge clk_i);
        set_rsp_ready();
        req_valid_i = 1'b0;
        #1;
        check("ram_ce_idle", {ram_ce_o, ram_we_o}, 5'b0);
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            idle_cycle();
            waited++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    function automatic logic [31:0] rand_addr(input bit oor);
        logic [31:0] a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        if (oor) a = a | (32'h1 << $urandom_range(12, 31));
        return a;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int acc_cnt, stalls, first_issue, bad;

        // Reset: RAM port must stay idle even with a request offered.
        repeat (2) @(negedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_be_i = 4'hF; req_addr_i = 32'h0;
        #1;
        check("reset_ram_ce", ram_ce_o, 0);
        check("reset_ram_we", ram_we_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1; req_valid_i = 1'b0;
        #1;
        check("post_reset_rsp_valid", rsp_valid_o, 0);
        check("post_reset_rsp_err", rsp_err_o, 0);
        check("post_reset_rsp_rdata", rsp_rdata_o, 0);
        check("post_reset_req_ready", req_ready_o, 1);

        // Preload the 16-word working set through the controller itself.
        rdy_mode = 1;
        for (int i = 0; i < 16; i++)
            send(1'b1, 4'hF, 32'(i * 4), (i == 4) ? 32'h1122_3344 : $urandom());
        drain();

        // Partial store then load of the same word.
        send(1'b1, 4'b0011, 32'h10, 32'hAABB_CCDD);
        send(1'b0, 4'h0, 32'h10, 32'h0);
        drain();
        check("partial_store_load", last_rdata, 32'h1122_CCDD);

        // Out-of-range load: RAM untouched, error response with zero data.
        send(1'b0, 4'h0, 32'h1000, 32'h0);
        drain();
        check("oor_err", last_err, 1);
        check("oor_rdata", last_rdata, 0);

        // Back-pressure: only three credits are available.
        rdy_mode = 0;
        acc_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            offer_cycle(1'b0, 4'h0, 32'(acc_cnt * 4), 32'h0, acc);
            acc_cnt += int'(acc);
        end
        check("bp_accepted", acc_cnt, 3);
        check("bp_req_ready", req_ready_o, 0);
        rdy_mode = 1;
        for (int i = 0; i < 20 && acc_cnt < 5; i++) begin
            offer_cycle(1'b0, 4'h0, 32'(acc_cnt * 4), 32'h0, acc);
            acc_cnt += int'(acc);
        end
        check("bp_rest_accepted", acc_cnt, 5);
        drain();

        // Throughput: 100 back-to-back loads with no stall and contiguous responses.
        idle_cycle();
        pop_cyc_q.delete();
        track = 1'b1;
        stalls = 0;
        first_issue = -1;
        for (int i = 0; i < 100; i++) begin
            acc = 1'b0;
            for (int w = 0; w < 10 && !acc; w++) begin
                offer_cycle(1'b0, 4'h0, rand_addr(1'b0), 32'h0, acc);
                if (!acc) stalls++;
            end
            if (first_issue < 0) first_issue = cyc;
        end
        drain();
        track = 1'b0;
        check("tput_stalls", stalls, 0);
        check("tput_rsp_count", pop_cyc_q.size(), 100);
        bad = 0;
        foreach (pop_cyc_q[i]) if (pop_cyc_q[i] != first_issue + 2 + i) bad++;
        check("tput_latency_contig", bad, 0);

        // Reset with two loads in flight: both must be dropped.
        rdy_mode = 0;
        send(1'b0, 4'h0, 32'h4, 32'h0);
        send(1'b0, 4'h0, 32'h8, 32'h0);
        @(negedge clk_i);
        rst_ni = 1'b0; rsp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'hC;
        exp_q.delete();
        #1;
        check("rst_flight_ram_ce", ram_ce_o, 0);
        check("rst_flight_ram_we", ram_we_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1; req_valid_i = 1'b0;
        #1;
        check("rst_flight_rsp_valid", rsp_valid_o, 0);
        check("rst_flight_req_ready", req_ready_o, 1);
        rdy_mode = 1;
        for (int i = 0; i < 5; i++) idle_cycle();

        // Randomized mix of loads, stores and errors under random back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++)
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 rand_addr($urandom_range(0, 7) == 0), $urandom());
        rdy_mode = 1;
        drain();

        // Zero-latency RAM: store, then load observed one cycle after issue.
        @(negedge clk_i);
        z_rsp_ready_i = 1'b1; z_req_valid_i = 1'b1; z_req_we_i = 1'b1;
        z_req_be_i = 4'hF; z_req_addr_i = 32'h1C; z_req_wdata_i = 32'hCAFE_F00D;
        #1;
        check("z_req_ready", z_req_ready_o, 1);
        check("z_store_ce", {z_ram_ce_o, z_ram_we_o}, 5'b1_1111);
        @(negedge clk_i);
        z_req_we_i = 1'b0;
        #1;
        check("z_store_rsp_valid", z_rsp_valid_o, 1);
        check("z_store_rsp_rdata", z_rsp_rdata_o, 0);
        check("z_load_ce", {z_ram_ce_o, z_ram_we_o}, 5'b1_0000);
        @(negedge clk_i);
        z_req_valid_i = 1'b0;
        #1;
        check("z_load_rsp_valid", z_rsp_valid_o, 1);
        check("z_load_rsp_rdata", z_rsp_rdata_o, 32'hCAFE_F00D);
        check("z_load_rsp_err", z_rsp_err_o, 0);
        @(negedge clk_i);
        #1;
        check("z_idle_rsp_valid", z_rsp_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
